parity_bist_ctrl: RTL and testbench

PARITY_BIST_CTRL -- requirements
Module: parity_bist_ctrl

---
 rtl/parity_bist_ctrl_if.sv | 24 ++
 rtl/parity_bist_ctrl.sv | 105 ++++++++++
 tb/tb_parity_bist_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/parity_bist_ctrl_if.sv
// rtl/parity_bist_ctrl_if.sv - start/result handshake and pattern bus of the parity BIST sequencer
interface parity_bist_ctrl_if;
  logic       start;
  logic       dut_p;
  logic       pat_a;
  logic       pat_b;
  logic       pat_c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_mask;
  logic [1:0] fault_class;

  modport master (
    output start, dut_p,
    input  pat_a, pat_b, pat_c, busy, done, pass, err_cnt, fail_mask, fault_class
  );

  modport slave (
    input  start, dut_p,
    output pat_a, pat_b, pat_c, busy, done, pass, err_cnt, fail_mask, fault_class
  );
endinterface

// File: rtl/parity_bist_ctrl.sv
// rtl/parity_bist_ctrl.sv - sweeps 8 patterns through a 3-input parity stage and classifies faults
// Define PARITY_BIST_ODD_EN to check an odd-parity generator instead of even parity.
module parity_bist_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_bist_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

`ifdef PARITY_BIST_ODD_EN
  localparam logic [7:0] MASK_SA0 = 8'h69;
  localparam logic [7:0] MASK_SA1 = 8'h96;
`else
  localparam logic [7:0] MASK_SA0 = 8'h96;
  localparam logic [7:0] MASK_SA1 = 8'h69;
`endif

  state_t     state;
  logic [2:0] idx;
  logic [3:0] settle_cnt;
  logic       golden;

`ifdef PARITY_BIST_ODD_EN
  assign golden = ~(bus.pat_a ^ bus.pat_b ^ bus.pat_c);
`else
  assign golden = bus.pat_a ^ bus.pat_b ^ bus.pat_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= 3'd0;
      settle_cnt      <= 4'd0;
      bus.pat_a       <= 1'b0;
      bus.pat_b       <= 1'b0;
      bus.pat_c       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.pass        <= 1'b0;
      bus.err_cnt     <= 4'd0;
      bus.fail_mask   <= 8'h00;
      bus.fault_class <= 2'b00;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx             <= 3'd0;
            settle_cnt      <= 4'd0;
            {bus.pat_a, bus.pat_b, bus.pat_c} <= 3'b000;
            bus.err_cnt     <= 4'd0;
            bus.fail_mask   <= 8'h00;
            bus.pass        <= 1'b0;
            bus.fault_class <= 2'b00;
            bus.busy        <= 1'b1;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          if (bus.dut_p != golden) begin
            bus.fail_mask[idx] <= 1'b1;
            bus.err_cnt        <= bus.err_cnt + 4'd1;
          end
          if (idx != 3'd7) begin
            idx <= idx + 3'd1;
            {bus.pat_a, bus.pat_b, bus.pat_c} <= idx + 3'd1;
            state <= WAIT;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          // err_cnt and fail_mask are final here; the last SAMPLE update has landed.
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          bus.pass <= (bus.err_cnt == 4'd0);
          if (bus.fail_mask == 8'h00)
            bus.fault_class <= 2'b00;
          else if (bus.fail_mask == MASK_SA0)
            bus.fault_class <= 2'b01;
          else if (bus.fail_mask == MASK_SA1)
            bus.fault_class <= 2'b10;
          else
            bus.fault_class <= 2'b11;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_bist_ctrl.sv
// tb/tb_parity_bist_ctrl.sv - directed checks of parity_bist_ctrl against healthy and faulty generator models
module tb_parity_bist_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  int         total;
  int         bad;
  int         lat;

  parity_bist_ctrl_if bif ();

  parity_bist_ctrl #(.SETTLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // 0 healthy, 1 p stuck-at-0, 2 p stuck-at-1, 3 input a stuck-at-0
  assign bif.dut_p = (mode == 2'd0) ? (bif.pat_a ^ bif.pat_b ^ bif.pat_c) :
                     (mode == 2'd1) ? 1'b0 :
                     (mode == 2'd2) ? 1'b1 :
                                      (bif.pat_b ^ bif.pat_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_outs"},
        {20'd0, bif.pat_a, bif.pat_b, bif.pat_c, bif.busy, bif.done, bif.pass,
         bif.fault_class, bif.err_cnt},
        32'd0);
    chk({tag, "_mask"}, {24'd0, bif.fail_mask}, 32'd0);
  endtask

  // start sampled on edge 0; returns the edge number at which done is seen
  task automatic sweep(input int repulse_at, output int n_done);
    n_done = -1;
    @(negedge clk);
    bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (n == repulse_at) bif.start = 1'b1;
      @(posedge clk);
      #1 bif.start = 1'b0;
      if (n == 5) chk("busy_mid", {31'd0, bif.busy}, 32'd1);
      if (bif.done) begin
        n_done = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic pass_e, input logic [3:0] cnt_e,
                              input logic [7:0] mask_e, input logic [1:0] cls_e);
    chk({tag, "_lat"}, lat, 25);
    chk({tag, "_busy"}, {31'd0, bif.busy}, 32'd0);
    chk({tag, "_pass"}, {31'd0, bif.pass}, {31'd0, pass_e});
    chk({tag, "_cnt"}, {28'd0, bif.err_cnt}, {28'd0, cnt_e});
    chk({tag, "_mask"}, {24'd0, bif.fail_mask}, {24'd0, mask_e});
    chk({tag, "_cls"}, {30'd0, bif.fault_class}, {30'd0, cls_e});
    chk({tag, "_pat"}, {29'd0, bif.pat_a, bif.pat_b, bif.pat_c}, 32'd7);
    @(posedge clk);
    #1 chk({tag, "_done1"}, {31'd0, bif.done}, 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    mode      = 2'd0;
    bif.start = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");

    // rst wins over a simultaneous start
    bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
    check_zero("rst_start");
    rst = 1'b0;

    mode = 2'd0;
    sweep(0, lat);
    check_result("healthy", 1'b1, 4'd0, 8'h00, 2'b00);

    mode = 2'd1;
    sweep(0, lat);
    check_result("p_sa0", 1'b0, 4'd4, 8'h96, 2'b01);
    repeat (4) @(posedge clk);
    #1 chk("hold_cnt", {28'd0, bif.err_cnt}, 32'd4);
    chk("hold_mask", {24'd0, bif.fail_mask}, 32'h96);

    mode = 2'd2;
    sweep(0, lat);
    check_result("p_sa1", 1'b0, 4'd4, 8'h69, 2'b10);

    mode = 2'd3;
    sweep(0, lat);
    check_result("a_sa0", 1'b0, 4'd4, 8'hF0, 2'b11);

    // reset while pattern 3 is on the bus
    mode = 2'd0;
    @(negedge clk);
    bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("pat3", {29'd0, bif.pat_a, bif.pat_b, bif.pat_c}, 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1 check_zero("mid_rst");
    rst = 1'b0;
    sweep(0, lat);
    check_result("after_rst", 1'b1, 4'd0, 8'h00, 2'b00);

    // start re-pulsed mid-sweep must not restart
    mode = 2'd1;
    sweep(10, lat);
    check_result("repulse", 1'b0, 4'd4, 8'h96, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
